// File: rtl/forthsuper_pkg.sv
// Shared types and opcode helpers for the threaded-code fetch stage.
package forthsuper_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ADR1, S_ADR2, S_DISP, S_DONE, S_ERR
  } fetch_sts;

  localparam logic [7:0] OP_EXIT  = 8'h00;
  localparam logic [7:0] OP_LIT   = 8'h01;
  localparam logic [7:0] OP_LIT2  = 8'h02;
  localparam int         CALL_BIT = 7;

  // Total encoded length of an instruction, opcode byte included.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    if (op[CALL_BIT])      return 2'd3;
    else if (op == OP_LIT)  return 2'd2;
    else if (op == OP_LIT2) return 2'd3;
    else                    return 2'd1;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; tos is the most recently pushed entry.
module ret_stack #(
  parameter int ASZ      = 17,
  parameter int RS_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [ASZ-1:0] din,
  output logic [ASZ-1:0] tos,
  output logic           full,
  output logic           empty
);
  localparam int PW = $clog2(RS_DEPTH) + 1;

  logic [ASZ-1:0] mem [RS_DEPTH];
  logic [PW-1:0]  sp;
  logic [PW-2:0]  tidx;

  assign tidx  = sp[PW-2:0] - 1'b1;
  assign tos   = mem[tidx];
  assign full  = (sp == PW'(RS_DEPTH));
  assign empty = (sp == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop)  sp <= sp - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[sp[PW-2:0]] <= din;
  end

endmodule

// File: rtl/op_fetch.sv
// Threaded-code fetch/dispatch: walks colon bodies, follows CALL/EXIT via a
// private return stack and hands primitives to the inner interpreter.
module op_fetch
  import forthsuper_pkg::*;
#(
  parameter int DSZ      = 8,
  parameter int ASZ      = 17,
  parameter int RS_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] ip0,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_re,
  input  logic [DSZ-1:0] mem_d,
  output logic           ex_en,
  output logic [DSZ-1:0] ex_op,
  output logic [ASZ-1:0] ex_pfa,
  input  logic           ex_bsy,
  output logic           busy,
  output logic           done,
  output logic           err
);

  fetch_sts       state, nxt;
  logic [ASZ-1:0] ip, mem_a_q, mem_a_c, rs_tos, target;
  logic [DSZ-1:0] op, hi;
  logic           first, mem_re_c, rs_push, rs_pop, rs_full, rs_empty;

  assign target = ASZ'({op[0], hi, mem_d});
  assign mem_a  = mem_a_c;
  assign mem_re = mem_re_c;
  assign done   = (state == S_DONE);

  ret_stack #(.ASZ(ASZ), .RS_DEPTH(RS_DEPTH)) u_rs (
    .clk(clk), .rst(rst), .push(rs_push), .pop(rs_pop),
    .din(ip + ASZ'(3)), .tos(rs_tos), .full(rs_full), .empty(rs_empty)
  );

  always_comb begin
    nxt      = state;
    mem_re_c = 1'b0;
    mem_a_c  = mem_a_q;
    rs_push  = 1'b0;
    rs_pop   = 1'b0;
    case (state)
      S_IDLE:   if (start) nxt = S_FETCH;
      S_FETCH:  begin mem_re_c = 1'b1; mem_a_c = ip; nxt = S_WAIT; end
      S_WAIT:   nxt = S_DECODE;
      S_DECODE: begin
        if (op == OP_EXIT) begin
          if (rs_empty) nxt = S_DONE;
          else begin rs_pop = 1'b1; nxt = S_FETCH; end
        end else if (op[CALL_BIT]) begin
          mem_re_c = 1'b1; mem_a_c = ip + ASZ'(1); nxt = S_ADR1;
        end else nxt = S_DISP;
      end
      S_ADR1:   begin mem_re_c = 1'b1; mem_a_c = ip + ASZ'(2); nxt = S_ADR2; end
      S_ADR2: begin
        if (rs_full) nxt = S_ERR;
        else begin rs_push = 1'b1; nxt = S_FETCH; end
      end
      // The interpreter may not have raised ex_bsy yet on the first cycle.
      S_DISP:   if (!first && !ex_bsy) nxt = S_FETCH;
      S_DONE:   nxt = S_IDLE;
      S_ERR:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ip      <= '0;
      op      <= '0;
      hi      <= '0;
      mem_a_q <= '0;
      first   <= 1'b0;
      ex_en   <= 1'b0;
      ex_op   <= '0;
      ex_pfa  <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= nxt;
      mem_a_q <= mem_a_c;
      case (state)
        S_IDLE: if (start) begin
          ip   <= ip0;
          err  <= 1'b0;
          busy <= 1'b1;
        end
        S_WAIT: op <= mem_d;
        S_DECODE: begin
          if (op == OP_EXIT) begin
            if (!rs_empty) ip <= rs_tos;
          end else if (!op[CALL_BIT]) begin
            ex_op  <= op;
            ex_pfa <= ip + ASZ'(1);
            ex_en  <= 1'b1;
            first  <= 1'b1;
          end
        end
        S_ADR1: hi <= mem_d;
        S_ADR2: begin
          if (rs_full) err <= 1'b1;
          else         ip  <= target;
        end
        S_DISP: begin
          first <= 1'b0;
          if (!first && !ex_bsy) begin
            ex_en <= 1'b0;
            ip    <= ip + ASZ'(op_len(op[7:0]));
          end
        end
        S_DONE, S_ERR: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_op_fetch.sv
// Bench for op_fetch: byte memory model, simple interpreter model, dispatch
// scoreboard, a vector table of programs and a few hand-written corner cases.
module tb_op_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [16:0] ip0 = '0;
  logic [16:0] mem_a;
  logic        mem_re;
  logic [7:0]  mem_d = '0;
  logic        ex_en;
  logic [7:0]  ex_op;
  logic [16:0] ex_pfa;
  logic        ex_bsy;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  op_fetch dut (
    .clk(clk), .rst(rst), .start(start), .ip0(ip0), .mem_a(mem_a),
    .mem_re(mem_re), .mem_d(mem_d), .ex_en(ex_en), .ex_op(ex_op),
    .ex_pfa(ex_pfa), .ex_bsy(ex_bsy), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:131071];
  always @(posedge clk) if (mem_re) mem_d <= mem[mem_a];

  // Interpreter: busy for the first two cycles of ex_en, done on the third.
  int   cnt = 0;
  logic hold_bsy = 1'b0;
  always @(posedge clk) cnt <= ex_en ? cnt + 1 : 0;
  assign ex_bsy = hold_bsy | (ex_en && cnt < 2);

  typedef struct packed {
    logic [7:0]  op;
    logic [16:0] pfa;
  } disp_t;
  disp_t q[$];

  typedef struct {
    logic [16:0]       ip0;
    int                n;
    logic [3:0][7:0]   op;
    logic [3:0][16:0]  pfa;
    bit                exp_err;
  } vec_t;
  vec_t tab [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: each new dispatch is compared with the oldest expectation.
  logic ex_en_d = 1'b0;
  always @(negedge clk) begin
    ex_en_d <= ex_en;
    if (ex_en && !ex_en_d) begin
      if (q.size() == 0) chk("unexpected dispatch", {24'h0, ex_op}, 32'hffff_ffff);
      else begin
        disp_t e;
        e = q.pop_front();
        chk("ex_op", {24'h0, ex_op}, {24'h0, e.op});
        chk("ex_pfa", {15'h0, ex_pfa}, {15'h0, e.pfa});
      end
    end
  end

  task automatic run_case(input vec_t v, input string nm, input int poke, input bit poke_done);
    bit fin;
    fin = 0;
    for (int i = 0; i < v.n; i++) q.push_back('{op: v.op[i], pfa: v.pfa[i]});
    @(negedge clk); start = 1'b1; ip0 = v.ip0;
    @(negedge clk); start = 1'b0;
    chk({nm, " busy after start"}, {31'h0, busy}, 1);
    chk({nm, " err cleared"}, {31'h0, err}, 0);
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk);
      if (c == poke) begin start = 1'b1; ip0 = 17'h00200; end
      else start = 1'b0;
      if (done) begin
        fin = 1;
        chk({nm, " ended by err"}, 0, {31'h0, v.exp_err});
        if (poke_done) begin start = 1'b1; ip0 = 17'h00100; end
        @(negedge clk); start = 1'b0;
        chk({nm, " busy after done"}, {31'h0, busy}, 0);
        chk({nm, " done pulse width"}, {31'h0, done}, 0);
        if (poke_done) begin
          repeat (3) @(negedge clk);
          chk({nm, " start in DONE busy"}, {31'h0, busy}, 0);
          chk({nm, " start in DONE mem_re"}, {31'h0, mem_re}, 0);
        end
      end else if (err) begin
        fin = 1;
        chk({nm, " ended by err"}, 1, {31'h0, v.exp_err});
        @(negedge clk);
        chk({nm, " busy after err"}, {31'h0, busy}, 0);
        chk({nm, " err sticky"}, {31'h0, err}, 1);
        chk({nm, " ex_en after err"}, {31'h0, ex_en}, 0);
      end
    end
    start = 1'b0;
    if (!fin) chk({nm, " timeout"}, 1, 0);
    chk({nm, " dispatches left"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    for (int a = 0; a < 131072; a++) mem[a] = 8'h00;
    mem[17'h00100] = 8'h05; mem[17'h00101] = 8'h06; mem[17'h00102] = 8'h00;
    mem[17'h00200] = 8'h01; mem[17'h00201] = 8'h2A; mem[17'h00202] = 8'h07;
    mem[17'h00203] = 8'h00;
    mem[17'h00300] = 8'h81; mem[17'h00301] = 8'h00; mem[17'h00302] = 8'h10;
    mem[17'h00303] = 8'h09; mem[17'h00304] = 8'h00;
    mem[17'h10010] = 8'h0B; mem[17'h10011] = 8'h00;
    mem[17'h00400] = 8'h80; mem[17'h00401] = 8'h04; mem[17'h00402] = 8'h00;
    mem[17'h1FFFF] = 8'h05; mem[17'h00000] = 8'h00;

    tab[0] = '{ip0: 17'h00100, n: 2, op: {8'h0, 8'h0, 8'h06, 8'h05},
               pfa: {17'h0, 17'h0, 17'h00102, 17'h00101}, exp_err: 0};
    tab[1] = '{ip0: 17'h00200, n: 2, op: {8'h0, 8'h0, 8'h07, 8'h01},
               pfa: {17'h0, 17'h0, 17'h00203, 17'h00201}, exp_err: 0};
    tab[2] = '{ip0: 17'h00300, n: 2, op: {8'h0, 8'h0, 8'h09, 8'h0B},
               pfa: {17'h0, 17'h0, 17'h00304, 17'h10011}, exp_err: 0};
    tab[3] = '{ip0: 17'h00400, n: 0, op: '0, pfa: '0, exp_err: 1};
    tab[4] = '{ip0: 17'h1FFFF, n: 1, op: {8'h0, 8'h0, 8'h0, 8'h05},
               pfa: {17'h0, 17'h0, 17'h0, 17'h00000}, exp_err: 0};

    #1;
    chk("reset mem_re", {31'h0, mem_re}, 0);
    chk("reset mem_a", {15'h0, mem_a}, 0);
    chk("reset ex_en", {31'h0, ex_en}, 0);
    chk("reset ex_op", {24'h0, ex_op}, 0);
    chk("reset ex_pfa", {15'h0, ex_pfa}, 0);
    chk("reset busy", {31'h0, busy}, 0);
    chk("reset done", {31'h0, done}, 0);
    chk("reset err", {31'h0, err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_case(tab[i], $sformatf("vec%0d", i), -1, 0);

    // start while busy is ignored; start in the DONE cycle is ignored too
    run_case(tab[0], "restart_busy", 3, 1);

    // async reset in the middle of a dispatch
    hold_bsy = 1'b1;
    q.push_back('{op: 8'h05, pfa: 17'h00101});
    @(negedge clk); start = 1'b1; ip0 = 17'h00100;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 50 && !ex_en; c++) @(negedge clk);
    chk("rst test ex_en seen", {31'h0, ex_en}, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid rst ex_en", {31'h0, ex_en}, 0);
    chk("mid rst busy", {31'h0, busy}, 0);
    chk("mid rst mem_re", {31'h0, mem_re}, 0);
    chk("mid rst ex_op", {24'h0, ex_op}, 0);
    q.delete();
    @(negedge clk); rst = 1'b1; hold_bsy = 1'b0;
    run_case(tab[0], "after_rst", -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1);
  end

endmodule
